// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - preload / settle / run / drain sequencer for a processor core and its data memory
// Optional build macro: RUN_CTRL_TIMEOUT_EN (abort a run after TIMEOUT_MAX cycles without done)
module run_ctrl #(
    parameter logic [7:0]  RES_BASE    = 8'd64,
    parameter int          RES_LEN     = 4,
    parameter int          SETTLE      = 2,
    parameter logic [15:0] TIMEOUT_MAX = 16'd4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        busy,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        core_start,
    input  logic        core_done,
    output logic        mem_own,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [15:0] cycles,
    output logic        timeout,
    output logic        fin
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_FIN} state_t;
    typedef enum logic [1:0] {D_WAIT, D_CAP, D_HOLD} dstep_t;

    state_t      state_q, state_d;
    dstep_t      dstep_q, dstep_d;
    logic        done_q, last_q, last_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  idx_q, idx_d;
    logic        busy_d, load_ready_d, core_start_d, mem_own_d, mem_we_d;
    logic [7:0]  mem_addr_d, mem_wdata_d, res_data_d;
    logic        res_valid_d, timeout_d, fin_d;
    logic [15:0] cycles_d;

`ifndef RUN_CTRL_TIMEOUT_EN
    logic unused_tmax;
    assign unused_tmax = ^TIMEOUT_MAX;
`endif

    always_comb begin
        state_d      = state_q;
        dstep_d      = dstep_q;
        last_d       = last_q;
        settle_d     = settle_q;
        idx_d        = idx_q;
        busy_d       = busy;
        load_ready_d = load_ready;
        core_start_d = core_start;
        mem_own_d    = mem_own;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        res_valid_d  = res_valid;
        res_data_d   = res_data;
        cycles_d     = cycles;
        timeout_d    = timeout;
        fin_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d      = S_LOAD;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b1;
                    cycles_d     = 16'd0;
                    timeout_d    = 1'b0;
                    last_d       = 1'b0;
                    mem_own_d    = 1'b1;
                end
            end
            S_LOAD: begin
                // last_q marks the cycle the final beat's write is on the bus
                if (last_q) begin
                    state_d      = S_SETTLE;
                    mem_own_d    = 1'b0;
                    core_start_d = 1'b0;
                    settle_d     = 4'd0;
                end else if (load_valid && load_ready) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = load_addr;
                    mem_wdata_d = load_data;
                    if (load_last) begin
                        load_ready_d = 1'b0;
                        last_d       = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'(SETTLE - 1)) begin
                    state_d      = S_RUN;
                    core_start_d = 1'b1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_RUN: begin
                if (done_q) begin
                    state_d      = S_DRAIN;
                    core_start_d = 1'b0;
                    mem_own_d    = 1'b1;
                    mem_addr_d   = RES_BASE;
                    idx_d        = 8'd0;
                    dstep_d      = D_WAIT;
                end
`ifdef RUN_CTRL_TIMEOUT_EN
                else if (cycles == TIMEOUT_MAX) begin
                    state_d      = S_FIN;
                    core_start_d = 1'b0;
                    mem_own_d    = 1'b1;
                    timeout_d    = 1'b1;
                    fin_d        = 1'b1;
                end
`endif
                else if (core_start && cycles != 16'hFFFF) begin
                    cycles_d = cycles + 16'd1;
                end
            end
            S_DRAIN: begin
                // address cycle, then data cycle, then capture and hold for the consumer
                case (dstep_q)
                    D_WAIT: dstep_d = D_CAP;
                    D_CAP: begin
                        res_data_d  = mem_rdata;
                        res_valid_d = 1'b1;
                        dstep_d     = D_HOLD;
                    end
                    D_HOLD: begin
                        if (res_ready) begin
                            res_valid_d = 1'b0;
                            if (idx_q == 8'(RES_LEN - 1)) begin
                                state_d = S_FIN;
                                fin_d   = 1'b1;
                            end else begin
                                idx_d      = idx_q + 8'd1;
                                mem_addr_d = RES_BASE + idx_q + 8'd1;
                                dstep_d    = D_WAIT;
                            end
                        end
                    end
                    default: dstep_d = D_WAIT;
                endcase
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dstep_q    <= D_WAIT;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
            settle_q   <= 4'd0;
            idx_q      <= 8'd0;
            busy       <= 1'b0;
            load_ready <= 1'b0;
            core_start <= 1'b0;
            mem_own    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 8'd0;
            res_valid  <= 1'b0;
            res_data   <= 8'd0;
            cycles     <= 16'd0;
            timeout    <= 1'b0;
            fin        <= 1'b0;
        end else begin
            state_q    <= state_d;
            dstep_q    <= dstep_d;
            done_q     <= (state_q == S_RUN) && core_done;
            last_q     <= last_d;
            settle_q   <= settle_d;
            idx_q      <= idx_d;
            busy       <= busy_d;
            load_ready <= load_ready_d;
            core_start <= core_start_d;
            mem_own    <= mem_own_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            res_valid  <= res_valid_d;
            res_data   <= res_data_d;
            cycles     <= cycles_d;
            timeout    <= timeout_d;
            fin        <= fin_d;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed-vector bench for run_ctrl (default and wrap/short-timeout instances)
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, go, sel;
    logic        load_valid, load_last, core_done, res_ready;
    logic [7:0]  load_addr, load_data;
    logic        go_a, go_b;

    logic        busy_a, load_ready_a, core_start_a, mem_own_a, mem_we_a, res_valid_a, timeout_a, fin_a;
    logic [7:0]  mem_addr_a, mem_wdata_a, res_data_a, rdata_a;
    logic [15:0] cycles_a;
    logic        busy_b, load_ready_b, core_start_b, mem_own_b, mem_we_b, res_valid_b, timeout_b, fin_b;
    logic [7:0]  mem_addr_b, mem_wdata_b, res_data_b, rdata_b;
    logic [15:0] cycles_b;

    logic        o_busy, o_load_ready, o_core_start, o_mem_own, o_mem_we, o_res_valid, o_timeout, o_fin;
    logic [7:0]  o_mem_addr, o_mem_wdata, o_res_data;
    logic [15:0] o_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign go_a = go & ~sel;
    assign go_b = go & sel;

    // result memory: every byte holds its own address XOR 8'h5A, one-cycle read latency
    always_ff @(posedge clk) begin
        rdata_a <= mem_addr_a ^ 8'h5A;
        rdata_b <= mem_addr_b ^ 8'h5A;
    end

    run_ctrl dut_a (
        .clk(clk), .rst(rst), .go(go_a), .busy(busy_a),
        .load_valid(load_valid), .load_ready(load_ready_a), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .core_start(core_start_a), .core_done(core_done),
        .mem_own(mem_own_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(rdata_a),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
        .cycles(cycles_a), .timeout(timeout_a), .fin(fin_a)
    );

    run_ctrl #(.RES_BASE(8'd254), .RES_LEN(4), .SETTLE(2), .TIMEOUT_MAX(16'd50)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .busy(busy_b),
        .load_valid(load_valid), .load_ready(load_ready_b), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .core_start(core_start_b), .core_done(core_done),
        .mem_own(mem_own_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(rdata_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .cycles(cycles_b), .timeout(timeout_b), .fin(fin_b)
    );

    always_comb begin
        o_busy       = sel ? busy_b       : busy_a;
        o_load_ready = sel ? load_ready_b : load_ready_a;
        o_core_start = sel ? core_start_b : core_start_a;
        o_mem_own    = sel ? mem_own_b    : mem_own_a;
        o_mem_we     = sel ? mem_we_b     : mem_we_a;
        o_mem_addr   = sel ? mem_addr_b   : mem_addr_a;
        o_mem_wdata  = sel ? mem_wdata_b  : mem_wdata_a;
        o_res_valid  = sel ? res_valid_b  : res_valid_a;
        o_res_data   = sel ? res_data_b   : res_data_a;
        o_cycles     = sel ? cycles_b     : cycles_a;
        o_timeout    = sel ? timeout_b    : timeout_a;
        o_fin        = sel ? fin_b        : fin_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic cond(input int what);
        case (what)
            0:       return o_core_start;
            1:       return !o_core_start;
            2:       return o_res_valid;
            default: return o_fin;
        endcase
    endfunction

    task automatic wait_for(input int what, input int limit, input string tag);
        int k = 0;
        while (!cond(what) && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, 32'(cond(what)), 32'd1);
    endtask

    task automatic start_run(input logic s, input logic [7:0] a, input logic [7:0] d);
        sel = s;
        go  = 1'b1;
        tick(1);
        go         = 1'b0;
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = 1'b1;
        tick(1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        wait_for(0, 20, "core_start_rise");
    endtask

    task automatic drain(input logic [7:0] base, input int n, input int stall_at);
        logic [7:0] ea;
        for (int i = 0; i < n; i++) begin
            ea = base + 8'(i);
            wait_for(2, 20, "res_valid_rise");
            check("rd_addr", 32'(o_mem_addr), 32'(ea));
            check("res_data", 32'(o_res_data), 32'(ea ^ 8'h5A));
            if (i == stall_at) begin
                tick(5);
                check("stall_valid", 32'(o_res_valid), 32'd1);
                check("stall_data", 32'(o_res_data), 32'(ea ^ 8'h5A));
                check("stall_addr", 32'(o_mem_addr), 32'(ea));
            end
            res_ready = 1'b1;
            tick(1);
            res_ready = 1'b0;
        end
        check("fin_pulse", 32'(o_fin), 32'd1);
        check("busy_in_fin", 32'(o_busy), 32'd1);
        tick(1);
        check("fin_end", 32'(o_fin), 32'd0);
        check("busy_after_fin", 32'(o_busy), 32'd0);
    endtask

    logic [7:0] b_addr [3] = '{8'd0, 8'd1, 8'd2};
    logic [7:0] b_data [3] = '{8'h05, 8'h07, 8'h00};
    logic       seen_valid;

    initial begin
        rst = 1'b0; go = 1'b0; sel = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_addr = 8'd0; load_data = 8'd0;
        core_done = 1'b0; res_ready = 1'b0;
        tick(3);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_load_ready", 32'(o_load_ready), 32'd0);
        check("rst_core_start", 32'(o_core_start), 32'd0);
        check("rst_mem_own", 32'(o_mem_own), 32'd1);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_res_valid", 32'(o_res_valid), 32'd0);
        check("rst_cycles", 32'(o_cycles), 32'd0);
        check("rst_timeout_fin", {o_timeout, o_fin}, 32'd0);
        rst = 1'b1;
        tick(1);

        // three preload beats, settle timing, long run, stalled drain
        go = 1'b1;
        tick(1);
        go = 1'b0;
        check("go_busy", 32'(o_busy), 32'd1);
        check("go_load_ready", 32'(o_load_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_addr  = b_addr[i];
            load_data  = b_data[i];
            load_last  = (i == 2);
            tick(1);
            check("wr_we", 32'(o_mem_we), 32'd1);
            check("wr_addr", 32'(o_mem_addr), 32'(b_addr[i]));
            check("wr_data", 32'(o_mem_wdata), 32'(b_data[i]));
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("ready_drop", 32'(o_load_ready), 32'd0);
        tick(1);
        check("settle_we", 32'(o_mem_we), 32'd0);
        check("settle_own", 32'(o_mem_own), 32'd0);
        check("settle_start0", 32'(o_core_start), 32'd0);
        tick(1);
        check("settle_start1", 32'(o_core_start), 32'd0);
        tick(1);
        check("start_rise", 32'(o_core_start), 32'd1);
        for (int k = 1; k <= 99; k++) begin
            tick(1);
            go = (k == 10);
            if (k == 12) begin
                check("run_go_ignored_cycles", 32'(o_cycles), 32'd12);
                check("run_go_ignored_start", 32'(o_core_start), 32'd1);
            end
        end
        core_done = 1'b1;
        tick(2);
        core_done = 1'b0;
        check("done_start", 32'(o_core_start), 32'd0);
        check("done_own", 32'(o_mem_own), 32'd1);
        check("done_cycles", 32'(o_cycles), 32'd100);
        drain(8'd64, 4, 1);

        // reset in the middle of a run
        start_run(1'b0, 8'h20, 8'h11);
        tick(10);
        rst = 1'b0;
        tick(1);
        check("midrst_start", 32'(o_core_start), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_own", 32'(o_mem_own), 32'd1);
        check("midrst_cycles", 32'(o_cycles), 32'd0);
        rst = 1'b1;
        tick(1);

        // result window wrapping past address 255
        start_run(1'b1, 8'h10, 8'h33);
        tick(5);
        core_done = 1'b1;
        wait_for(1, 10, "wrap_done_stop");
        core_done = 1'b0;
        drain(8'd254, 4, -1);

        // run with no done
        start_run(1'b1, 8'h11, 8'h44);
`ifdef RUN_CTRL_TIMEOUT_EN
        seen_valid = 1'b0;
        for (int k = 0; k < 100 && !o_fin; k++) begin
            tick(1);
            seen_valid = seen_valid | o_res_valid;
        end
        check("to_fin", 32'(o_fin), 32'd1);
        check("to_flag", 32'(o_timeout), 32'd1);
        check("to_no_valid", 32'(seen_valid), 32'd0);
        check("to_start", 32'(o_core_start), 32'd0);
        check("to_cycles", 32'(o_cycles), 32'd50);
        tick(1);
        check("to_idle_busy", 32'(o_busy), 32'd0);
        check("to_held", 32'(o_timeout), 32'd1);
`else
        seen_valid = 1'b0;
        tick(1000);
        check("nto_start", 32'(o_core_start), 32'd1);
        check("nto_busy", 32'(o_busy), 32'd1);
        check("nto_timeout", 32'(o_timeout), 32'd0);
        check("nto_cycles", 32'(o_cycles), 32'd1000);
`endif
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RES_BASE, default 8'd64: first data-memory address read back after a run.
REQ-002 SHALL have parameter RES_LEN, default 4: number of result bytes read back, range 1..255.
REQ-003 SHALL have parameter SETTLE, default 2: cycles core_start is held low before a run, range 1..15.
REQ-004 SHALL have parameter TIMEOUT_MAX, default 16'd4000: run-cycle limit used only when RUN_CTRL_TIMEOUT_EN is defined.
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-low reset
  go  in  1  run request, sampled in IDLE only
  busy  out  1  high from the cycle after go is accepted until FIN ends
  load_valid  in  1  preload beat valid
  load_ready  out  1  preload beat accepted
  load_addr  in  8  preload data-memory address
  load_data  in  8  preload byte
  load_last  in  1  final preload beat
  core_start  out  1  drives processor start; low holds the core in reset
  core_done  in  1  processor done flag
  mem_own  out  1  1 = controller owns the data-memory port, 0 = core owns it
  mem_we  out  1  data-memory write strobe
  mem_addr  out  8  data-memory address
  mem_wdata  out  8  data-memory write byte
  mem_rdata  in  8  data-memory read byte, valid one cycle after mem_addr
  res_valid  out  1  result byte valid
  res_ready  in  1  result byte consumed
  res_data  out  8  result byte
  cycles  out  16  cycle count of the last or current run
  timeout  out  1  run aborted by timeout
  fin  out  1  one-cycle pulse at sequence end

Function
REQ-006 SHALL implement states IDLE, LOAD, SETTLE, RUN, DRAIN, FIN.
REQ-007 SHALL, in IDLE with go=1, clear cycles and timeout and enter LOAD; go SHALL be ignored in all other states.
REQ-008 SHALL, in LOAD, drive load_ready=1; a beat transfers when load_valid and load_ready are both 1.
REQ-009 SHALL register each transferred beat into mem_we=1, mem_addr=load_addr, mem_wdata=load_data for exactly one cycle, starting the cycle after the transfer.
REQ-010 SHALL, on a beat with load_last=1, deassert load_ready the next cycle and enter SETTLE after that beat's write has issued.
REQ-011 SHALL, in SETTLE, drive mem_own=0 and core_start=0 for SETTLE cycles, then enter RUN with core_start=1.
REQ-012 SHALL, in RUN, increment cycles once per cycle while core_start=1, saturating at 16'hFFFF.
REQ-013 SHALL register core_done and, when the registered value is 1 in RUN, drive core_start=0 and mem_own=1 on the next edge and enter DRAIN; core_done SHALL be ignored outside RUN.
REQ-014 SHALL, in DRAIN, read addresses RES_BASE+i for i=0..RES_LEN-1, with the address wrapping modulo 256 and at most one read outstanding.
REQ-015 SHALL, in DRAIN, hold res_valid and res_data stable until res_ready=1, and issue the next read only after the current byte is consumed.
REQ-016 SHALL, after the final result byte is consumed, enter FIN, pulse fin for one cycle, then return to IDLE with busy=0.
REQ-017 SHALL drive mem_we=0 in every state except the LOAD write cycle defined in REQ-009.

Reset
REQ-018 SHALL, with rst=0 at a clock edge, enter IDLE from any state including mid-run.
REQ-019 SHALL reset these outputs: busy=0, load_ready=0, core_start=0, mem_own=1, mem_we=0, mem_addr=0, mem_wdata=0, res_valid=0, res_data=0, cycles=0, timeout=0, fin=0.

Configuration
REQ-020 SHALL, with RUN_CTRL_TIMEOUT_EN defined, abort RUN when cycles equals TIMEOUT_MAX without done, set timeout=1 (held until the next accepted go), drop core_start, skip DRAIN and enter FIN.
REQ-021 SHALL, without RUN_CTRL_TIMEOUT_EN, wait in RUN indefinitely and tie timeout to 0.

Verification
REQ-022 SHALL check: 3 preload beats (addr 0/1/2, data 8'h05/8'h07/8'h00, last on beat 3) -> three one-cycle mem_we pulses carrying those exact addr/data pairs, then core_start rises exactly 2 cycles after SETTLE entry.
REQ-023 SHALL check: core_done asserted 100 cycles after core_start rises -> cycles=100 (+/-1 per the done register), core_start=0, 4 reads at addresses 64..67.
REQ-024 SHALL check: res_ready held low 5 cycles during DRAIN -> res_data unchanged and no new mem_addr issued; with RES_BASE=254 and RES_LEN=4 -> read addresses 254, 255, 0, 1.
REQ-025 SHALL check: rst=0 asserted mid-RUN -> next cycle core_start=0, busy=0, state IDLE; a go in RUN -> no effect.
REQ-026 SHALL check: with RUN_CTRL_TIMEOUT_EN and TIMEOUT_MAX=50, no done -> timeout=1 and fin pulse with no res_valid; without the macro -> still in RUN at cycle 1000.
